// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared definitions for the memory port arbiter: bus width
//            defaults, fairness limit default and the arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Default bus widths shared by the core and its memory arbiter
  localparam int CPU_DATA_W     = 32;
  localparam int CPU_ADDR_W     = 32;

  // Default number of back-to-back data grants tolerated while a fetch waits
  localparam int CPU_STARVE_MAX = 2;

  // Arbiter state encoding
  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_I = 3'd1,
    ARB_BUSY_D = 3'd2,
    ARB_RESP_I = 3'd3,
    ARB_RESP_D = 3'd4
  } arb_state_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one synchronous single-port memory between the fetch
//            stage and the memory stage. Data requests have priority; each
//            access takes three cycles (grant, memory cycle, response).
//            Optional macro MEM_ARB_FAIRNESS_EN bounds fetch starvation to
//            STARVE_MAX consecutive data grants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W     = CPU_DATA_W,
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int STARVE_MAX = CPU_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  // shared memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // pipeline stalls
  output logic              stall_f,
  output logic              stall_m
);

  arb_state_t        state, next_state;
  logic              grant_i, grant_d;
  logic              fetch_forced;
  logic              access_we;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

`ifdef MEM_ARB_FAIRNESS_EN
  // Wide enough to hold STARVE_MAX, and at least one bit when it is zero
  localparam int CNT_W = $clog2(STARVE_MAX + 2);

  logic [CNT_W-1:0] starve_cnt;

  // Fetch wins the next IDLE grant once the data port has used up its quota
  assign fetch_forced = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

  // Count data grants taken while a fetch is waiting; a fetch grant clears it
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && if_req) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign fetch_forced = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant decode; reset overrides everything back to IDLE
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (dm_req && !fetch_forced) begin
          grant_d    = 1'b1;
          next_state = ARB_BUSY_D;
        end else if (if_req) begin
          grant_i    = 1'b1;
          next_state = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I: next_state = ARB_RESP_I;
      ARB_BUSY_D: next_state = ARB_RESP_D;
      ARB_RESP_I: next_state = ARB_IDLE;
      ARB_RESP_D: next_state = ARB_IDLE;
      default:    next_state = ARB_IDLE;
    endcase
    if (reset) begin
      next_state = ARB_IDLE;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
    end
  end

  // Registered memory command, ready pulses and held read data
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      access_we  <= 1'b0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      // enable is high only for the BUSY cycle that follows a grant
      mem_en   <= grant_i | grant_d;
      mem_we   <= grant_d & dm_we;
      if (grant_i || grant_d) begin
        mem_addr  <= grant_d ? dm_addr  : if_addr;
        mem_wdata <= grant_d ? dm_wdata : '0;
        access_we <= grant_d & dm_we;
      end
      // ready lands in the RESP cycle, two cycles after the grant
      if_ready <= (state == ARB_BUSY_I);
      dm_ready <= (state == ARB_BUSY_D);
      if (state == ARB_RESP_I) begin
        if_rdata_q <= mem_rdata;
      end
      if (state == ARB_RESP_D) begin
        dm_rdata_q <= access_we ? '0 : mem_rdata;
      end
    end
  end

  // Memory data is only valid during RESP, so pass it straight through
  // then and present the held copy afterwards
  assign if_rdata = (state == ARB_RESP_I) ? mem_rdata : if_rdata_q;
  assign dm_rdata = (state == ARB_RESP_D) ? (access_we ? '0 : mem_rdata)
                                          : dm_rdata_q;

  assign stall_f = if_req & ~if_ready;
  assign stall_m = dm_req & ~dm_ready;

endmodule : mem_port_arbiter

`default_nettype wire
